tcp_logger_record: RTL and testbench
====================================

Name: tcp_logger_record

Overview:
- Write-side counterpart of the TCP logger read path.
- Captures log entries produced by the TCP engine and writes them sequentially into the logger memory.
- Publishes the committed-entry count on recorder_read_curr_addr, which bounds what the read side may return.
- Never backpressures the TCP engine: entries that cannot be stored are dropped and counted.

Parameters:
- LOG_ENTRIES_LOG_2, 10, log2 of logger memory depth.
- LOG_ADDR_W, LOG_ENTRIES_LOG_2, memory address width.
- DROP_CNT_W, 32, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- record_start  in  1  single-cycle pulse; arm recording.
- record_clear  in  1  single-cycle pulse; stop recording and rewind to 0.
- log_entry_val  in  1  TCP engine has an entry this cycle. No rdy is returned.
- log_entry  in  log_entry_struct  entry payload.
- wr_req_logger_mem_val  out  1  memory write valid.
- wr_req_logger_mem_addr  out  LOG_ADDR_W  write address.
- wr_req_logger_mem_entry  out  log_entry_struct  write data.
- wr_req_logger_mem_rdy  in  1  memory accepts the write.
- recorder_read_curr_addr  out  LOG_ADDR_W+1  number of committed entries, 0..2^LOG_ADDR_W.
- recorder_full  out  1  state is FULL.
- recorder_active  out  1  state is RECORD.
- recorder_drop_cnt  out  DROP_CNT_W  entries dropped while in RECORD; saturating.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - recorder_read_curr_addr = 0
  - recorder_drop_cnt = 0
  - buffer empty, so wr_req_logger_mem_val = 0
  - wr_req_logger_mem_addr = 0, entry = 0
  - recorder_full = 0, recorder_active = 0
- Reset mid-write: the buffered entry is discarded and the count is not incremented.
- States:
  - IDLE: log_entry_val is ignored and not counted as a drop.
  - RECORD: entries are captured.
  - FULL: entries are ignored; each log_entry_val increments drop_cnt.
- Transitions:
  - IDLE -> RECORD on record_start.
  - RECORD -> FULL on the cycle a write commits that makes curr_addr == 2^LOG_ADDR_W.
  - Any state -> IDLE on record_clear.
  - record_start in RECORD or FULL has no effect.
  - record_clear and record_start in the same cycle: clear wins, ending in IDLE.
- record_clear effects, next cycle:
  - curr_addr = 0 and drop_cnt = 0.
  - The buffered entry is discarded; wr_req val drops.
- Buffer:
  - One-entry output register holding {val, addr, entry}; it drives the wr_req_* ports directly.
  - Write commit = val & rdy. On commit, curr_addr increments by 1 the following cycle.
  - curr_addr counts committed writes only. The reader never sees an address whose write is pending.
  - An entry captured at cycle t appears on wr_req at t+1; sustained throughput is 1 entry/cycle.
- Capture in RECORD requires log_entry_val plus both conditions:
  - space: curr_addr + buf_val < 2^LOG_ADDR_W, computed in LOG_ADDR_W+2 bits. This reserves the slot held in the buffer.
  - slot: buffer empty, or the buffer is committing this cycle.
- On capture:
  - addr = (curr_addr + (commit ? 1 : 0)) truncated to LOG_ADDR_W bits; it always equals the slot index of that entry.
  - The entry is registered unmodified.
- Any log_entry_val in RECORD that is not captured increments drop_cnt.
- drop_cnt saturates at all-ones.
- No wrap-around: the memory is filled once per clear. The address never exceeds 2^LOG_ADDR_W-1, and curr_addr holds at 2^LOG_ADDR_W.
- wr_req val/addr/entry stay stable while val=1 and rdy=0.

Decomposition:
- tcp_logger_pkg (shared with the read path) holds:
  - log_entry_struct
  - logger_record_state_e {IDLE, RECORD, FULL}
  - LOG_ENTRY_W
- One natural sub-module, tcp_logger_record_ctrl: state machine plus capture/drop decisions.
- The top holds the output register, curr_addr and drop counters, mirroring the read-side ctrl/datap split.

Test Plan (all with LOG_ENTRIES_LOG_2=3):
- Reset asserted mid-run (buffer full, rdy=0): outputs go to reset values immediately; curr_addr=0 and no write after release.
- record_start, then 5 back-to-back entries with rdy=1: writes to addrs 0..4 on consecutive cycles; curr_addr=5; drop_cnt=0.
- Continue to 12 entries total: addrs 0..7 written; curr_addr=8; recorder_full=1; drop_cnt=4; no 9th write.
- rdy=0 for 3 cycles while 4 entries arrive: first is buffered and held stable at addr 0; other 3 dropped (drop_cnt=3); curr_addr=1 after rdy returns.
- record_clear with a pending write and rdy=0: next cycle wr val=0, curr_addr=0, drop_cnt=0, state IDLE; entries in IDLE are neither written nor counted.
- record_clear and record_start in the same cycle: state is IDLE; a subsequent record_start then a single entry writes addr 0.

Source files
------------

// File: rtl/tcp_logger_pkg.sv
// tcp_logger_pkg: shared types for the TCP logger record/read paths
package tcp_logger_pkg;
  typedef struct packed {
    logic [31:0] ts;
    logic [7:0]  kind;
    logic [23:0] info;
  } log_entry_struct;
  localparam int LOG_ENTRY_W = $bits(log_entry_struct);
  typedef enum logic [1:0] {IDLE, RECORD, FULL} logger_record_state_e;
endpackage

// File: rtl/tcp_logger_record_ctrl.sv
// tcp_logger_record_ctrl: recorder state machine plus capture/drop decisions
// Ports: record_start/record_clear pulses, log_entry_val, buffer status (buf_val, commit),
// committed count curr_addr in; capture/drop strobes and registered full_q/active_q out.
module tcp_logger_record_ctrl
  import tcp_logger_pkg::*;
#(
  parameter int LOG_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                record_start,
  input  logic                record_clear,
  input  logic                log_entry_val,
  input  logic                buf_val,
  input  logic                commit,
  input  logic [LOG_ADDR_W:0] curr_addr,
  output logic                capture,
  output logic                drop,
  output logic                full_q,
  output logic                active_q
);
  localparam logic [LOG_ADDR_W+1:0] DEPTH = {2'b01, {LOG_ADDR_W{1'b0}}};
  logger_record_state_e state_q, state_d;
  logic space, slot, last;
  // the slot held in the buffer is reserved, so a full buffer at depth-1 blocks capture
  assign space   = ({1'b0, curr_addr} + (LOG_ADDR_W+2)'(buf_val)) < DEPTH;
  assign slot    = !buf_val || commit;
  assign capture = state_q == RECORD && !record_clear && log_entry_val && space && slot;
  assign drop    = log_entry_val && !record_clear && (state_q == FULL || (state_q == RECORD && !capture));
  assign last    = commit && curr_addr == (LOG_ADDR_W+1)'(DEPTH - 1'b1);
  always_comb begin
    state_d = record_clear                      ? IDLE   :
              (state_q == IDLE && record_start) ? RECORD :
              (state_q == RECORD && last)       ? FULL   : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      full_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= state_d == FULL;
      active_q <= state_d == RECORD;
    end
  end
endmodule

// File: rtl/tcp_logger_record.sv
// tcp_logger_record: captures TCP engine log entries and writes them sequentially to logger memory
// Ports: record_start/record_clear control, log_entry_val/log_entry from the engine (no rdy),
// wr_req_logger_mem_* one-entry write port, committed count, full/active status and drop count.
module tcp_logger_record
  import tcp_logger_pkg::*;
#(
  parameter int LOG_ENTRIES_LOG_2 = 10,
  parameter int LOG_ADDR_W        = LOG_ENTRIES_LOG_2,
  parameter int DROP_CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  record_start,
  input  logic                  record_clear,
  input  logic                  log_entry_val,
  input  log_entry_struct       log_entry,
  output logic                  wr_req_logger_mem_val,
  output logic [LOG_ADDR_W-1:0] wr_req_logger_mem_addr,
  output log_entry_struct       wr_req_logger_mem_entry,
  input  logic                  wr_req_logger_mem_rdy,
  output logic [LOG_ADDR_W:0]   recorder_read_curr_addr,
  output logic                  recorder_full,
  output logic                  recorder_active,
  output logic [DROP_CNT_W-1:0] recorder_drop_cnt
);
  logic                  buf_val_q, buf_val_d;
  logic [LOG_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  log_entry_struct       buf_entry_q, buf_entry_d;
  logic [LOG_ADDR_W:0]   curr_q, curr_d, base;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  commit, capture, drop;
  assign commit = buf_val_q && wr_req_logger_mem_rdy;
  // count after this cycle's commit; also the slot index of an entry captured now
  assign base   = curr_q + (LOG_ADDR_W+1)'(commit);
  tcp_logger_record_ctrl #(.LOG_ADDR_W(LOG_ADDR_W)) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .record_start (record_start),
    .record_clear (record_clear),
    .log_entry_val(log_entry_val),
    .buf_val      (buf_val_q),
    .commit       (commit),
    .curr_addr    (curr_q),
    .capture      (capture),
    .drop         (drop),
    .full_q       (recorder_full),
    .active_q     (recorder_active)
  );
  always_comb begin
    curr_d      = record_clear ? '0 : base;
    buf_val_d   = record_clear ? 1'b0 : capture || (buf_val_q && !commit);
    buf_addr_d  = capture ? base[LOG_ADDR_W-1:0] : buf_addr_q;
    buf_entry_d = capture ? log_entry : buf_entry_q;
    drop_d      = record_clear ? '0 : (drop && !(&drop_q)) ? drop_q + DROP_CNT_W'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_val_q   <= 1'b0;
      buf_addr_q  <= '0;
      buf_entry_q <= '0;
      curr_q      <= '0;
      drop_q      <= '0;
    end else begin
      buf_val_q   <= buf_val_d;
      buf_addr_q  <= buf_addr_d;
      buf_entry_q <= buf_entry_d;
      curr_q      <= curr_d;
      drop_q      <= drop_d;
    end
  end
  assign wr_req_logger_mem_val   = buf_val_q;
  assign wr_req_logger_mem_addr  = buf_addr_q;
  assign wr_req_logger_mem_entry = buf_entry_q;
  assign recorder_read_curr_addr = curr_q;
  assign recorder_drop_cnt       = drop_q;
endmodule

// File: tb/tb_tcp_logger_record.sv
// tb_tcp_logger_record: directed plus randomized checks of tcp_logger_record against a reference model
module tb_tcp_logger_record;
  import tcp_logger_pkg::*;
  localparam int W = 3;
  localparam int DEPTH = 1 << W;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic            record_start = 1'b0, record_clear = 1'b0, log_entry_val = 1'b0, rdy = 1'b0;
  log_entry_struct log_entry = '0;
  logic            wr_val;
  logic [W-1:0]    wr_addr;
  log_entry_struct wr_entry;
  logic [W:0]      curr;
  logic            full, active;
  logic [31:0]     drop_cnt;
  int checks = 0, errors = 0;
  int m_mode, m_cnt, m_pa;
  bit m_pv;
  log_entry_struct m_pe;
  longint m_drop;
  tcp_logger_record #(.LOG_ENTRIES_LOG_2(W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .record_start           (record_start),
    .record_clear           (record_clear),
    .log_entry_val          (log_entry_val),
    .log_entry              (log_entry),
    .wr_req_logger_mem_val  (wr_val),
    .wr_req_logger_mem_addr (wr_addr),
    .wr_req_logger_mem_entry(wr_entry),
    .wr_req_logger_mem_rdy  (rdy),
    .recorder_read_curr_addr(curr),
    .recorder_full          (full),
    .recorder_active        (active),
    .recorder_drop_cnt      (drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic log_entry_struct rand_entry();
    return log_entry_struct'({$urandom, $urandom});
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pv = 0; m_pa = 0; m_pe = '0; m_drop = 0;
  endtask
  // mode: 0 idle, 1 record, 2 full; m_cnt = committed entries, m_pv/m_pa/m_pe = pending write
  task automatic model_step();
    bit c;
    c = m_pv && rdy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (record_clear) begin
      m_mode = 0; m_cnt = 0; m_drop = 0; m_pv = 0;
      return;
    end
    if (m_mode == 1 && log_entry_val) begin
      if (m_cnt + int'(m_pv) < DEPTH && (!m_pv || c)) begin
        m_pa = m_cnt + int'(c);
        m_pe = log_entry;
        m_pv = 1;
      end else begin
        m_drop++;
        m_pv = m_pv && !c;
      end
    end else m_pv = m_pv && !c;
    if (m_mode == 2 && log_entry_val) m_drop++;
    m_cnt += int'(c);
    if (m_mode == 0 && record_start) m_mode = 1;
    else if (m_mode == 1 && m_cnt == DEPTH) m_mode = 2;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".val"}, 64'(wr_val), 64'(m_pv));
    if (m_pv) begin
      chk({tag, ".addr"}, 64'(wr_addr), 64'(m_pa));
      chk({tag, ".entry"}, 64'(wr_entry), 64'(m_pe));
    end
    chk({tag, ".curr"}, 64'(curr), 64'(m_cnt));
    chk({tag, ".full"}, 64'(full), 64'(m_mode == 2));
    chk({tag, ".active"}, 64'(active), 64'(m_mode == 1));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset.addr", 64'(wr_addr), 64'(0));
    chk("reset.entry", 64'(wr_entry), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick("idle");
    // reset while a write is pending with rdy low
    record_start = 1'b1; tick("mr_start"); record_start = 1'b0;
    log_entry_val = 1'b1; log_entry = rand_entry(); rdy = 1'b0;
    tick("mr_cap"); log_entry_val = 1'b0;
    tick("mr_hold");
    chk("mr_pending", 64'(wr_val), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.addr", 64'(wr_addr), 64'(0));
    chk("async_rst.entry", 64'(wr_entry), 64'(0));
    tick("in_rst");
    rst_n = 1'b1; rdy = 1'b1;
    tick("post_rst0"); tick("post_rst1");
    chk("post_rst.curr", 64'(curr), 64'(0));
    chk("post_rst.val", 64'(wr_val), 64'(0));
    // five back-to-back entries
    record_start = 1'b1; tick("f_start"); record_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      log_entry_val = 1'b1; log_entry = rand_entry(); tick("fill5");
    end
    log_entry_val = 1'b0;
    tick("fill5_d0"); tick("fill5_d1");
    chk("fill5.curr", 64'(curr), 64'(5));
    chk("fill5.drop", 64'(drop_cnt), 64'(0));
    // seven more: three fit, four dropped
    for (int i = 0; i < 7; i++) begin
      log_entry_val = 1'b1; log_entry = rand_entry(); tick("fill12");
    end
    log_entry_val = 1'b0;
    tick("fill12_d0"); tick("fill12_d1");
    chk("fill12.curr", 64'(curr), 64'(8));
    chk("fill12.full", 64'(full), 64'(1));
    chk("fill12.drop", 64'(drop_cnt), 64'(4));
    chk("fill12.val", 64'(wr_val), 64'(0));
    // stall: first entry held, rest dropped
    record_clear = 1'b1; tick("s_clear"); record_clear = 1'b0;
    record_start = 1'b1; tick("s_start"); record_start = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      log_entry_val = 1'b1; log_entry = rand_entry(); tick("stall");
    end
    log_entry_val = 1'b0;
    chk("stall.addr", 64'(wr_addr), 64'(0));
    chk("stall.drop", 64'(drop_cnt), 64'(3));
    rdy = 1'b1; tick("stall_r0"); tick("stall_r1");
    chk("stall.curr", 64'(curr), 64'(1));
    // clear while a write is pending
    rdy = 1'b0; log_entry_val = 1'b1; log_entry = rand_entry(); tick("c_cap"); log_entry_val = 1'b0;
    chk("c_pending", 64'(wr_val), 64'(1));
    record_clear = 1'b1; tick("c_clear"); record_clear = 1'b0;
    chk("c_clear.val", 64'(wr_val), 64'(0));
    chk("c_clear.curr", 64'(curr), 64'(0));
    chk("c_clear.drop", 64'(drop_cnt), 64'(0));
    chk("c_clear.active", 64'(active), 64'(0));
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      log_entry_val = 1'b1; log_entry = rand_entry(); tick("idle_ev");
    end
    log_entry_val = 1'b0;
    chk("idle_ev.drop", 64'(drop_cnt), 64'(0));
    chk("idle_ev.val", 64'(wr_val), 64'(0));
    // clear and start together: clear wins
    record_clear = 1'b1; record_start = 1'b1; tick("cs"); record_clear = 1'b0; record_start = 1'b0;
    chk("cs.active", 64'(active), 64'(0));
    record_start = 1'b1; tick("cs_start"); record_start = 1'b0;
    log_entry_val = 1'b1; log_entry = rand_entry(); tick("cs_cap"); log_entry_val = 1'b0;
    chk("cs_cap.val", 64'(wr_val), 64'(1));
    chk("cs_cap.addr", 64'(wr_addr), 64'(0));
    tick("cs_commit");
    chk("cs_commit.curr", 64'(curr), 64'(1));
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      log_entry_val = $urandom_range(0, 3) != 0;
      rdy           = $urandom_range(0, 2) != 0;
      record_clear  = $urandom_range(0, 59) == 0;
      record_start  = $urandom_range(0, 7) == 0;
      log_entry     = rand_entry();
      tick("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
